// File: rtl/arm_pkg.sv
// arm_pkg: shared definitions for the ARM front end.
//   fetch_st_e    : fetch state machine encoding (IDLE/REQ/WAIT/DROP)
//   ARM_RESET_PC  : default fetch address after reset
//   INST_W        : instruction width
//   PC_INC        : sequential fetch increment
//   align_word()  : clears address bits [1:0]
package arm_pkg;

  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] ARM_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_st_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/arm_fetch_queue.sv
// arm_fetch_queue: 2-entry synchronous prefetch FIFO with registered head.
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_inst/pc  : write an entry (caller guarantees room)
//   pop                 : drop the head entry
//   clear               : empty the queue; dominates push and pop
//   head_inst, head_pc  : registered head entry
//   count               : number of valid entries (0..2)
module arm_fetch_queue
  import arm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [31:0]       push_pc,
  input  logic              pop,
  input  logic              clear,
  output logic [INST_W-1:0] head_inst,
  output logic [31:0]       head_pc,
  output logic [1:0]        count
);

  fetch_entry_t ent0, ent1, din;

  assign din       = '{inst: push_inst, pc: push_pc};
  assign head_inst = ent0.inst;
  assign head_pc   = ent0.pc;

  // Shift-register organisation: ent0 is always the head, so the
  // outputs come straight from a register with no read mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      unique case ({push, pop && (count != 2'd0)})
        2'b10: begin
          if (count == 2'd0) begin
            ent0  <= din;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            ent1  <= din;
            count <= 2'd2;
          end
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/arm_fetch.sv
// arm_fetch: instruction fetch unit feeding arm_decode.
//   RESET_PC     : fetch address after reset (word aligned)
//   clk, rst     : clock, asynchronous active-high reset
//   imem_req/addr/gnt/rvalid/rdata : instruction memory read port,
//                  at most one request outstanding
//   inst_valid/ready, inst, inst_pc : instruction stream to decode
//   pc_we, pc_in : redirect; flushes queue and in-flight fetch
// Build option ARM_FETCH_PC8_EN: inst_pc reports fetch address + 8
// (R15 as seen by the executing instruction) instead of the raw address.
module arm_fetch
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ARM_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  input  logic              pc_we,
  input  logic [31:0]       pc_in
);

  fetch_st_e   st, st_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] push_pc;
  logic [1:0]  count;
  logic        outstanding;
  logic        grant;
  logic        push;
  logic        pop;

  assign outstanding = (st == WAIT) || (st == DROP);
  assign grant       = imem_req && imem_gnt;
  assign push        = (st == WAIT) && imem_rvalid;
  assign pop         = inst_valid && inst_ready;
  assign imem_addr   = fetch_pc;
  assign inst_valid  = (count != 2'd0);

`ifdef ARM_FETCH_PC8_EN
  assign push_pc = req_pc + 32'd8;
`else
  assign push_pc = req_pc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    imem_req = 1'b0;
    unique case (st)
      IDLE: st_nxt = REQ;
      REQ: begin
        // Only ask when the response is guaranteed a queue slot.
        imem_req = ((count + {1'b0, outstanding}) < 2'd2) && !pc_we;
        if (imem_req && imem_gnt) st_nxt = WAIT;
      end
      WAIT: if (imem_rvalid) st_nxt = REQ;
      DROP: if (imem_rvalid) st_nxt = REQ;
      default: st_nxt = IDLE;
    endcase
    // A response landing in the redirect cycle is discarded here, so
    // only a still-pending one needs the DROP detour.
    if (pc_we) st_nxt = (outstanding && !imem_rvalid) ? DROP : REQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (pc_we) begin
      fetch_pc <= align_word(pc_in);
    end else if (grant) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + PC_INC;
    end
  end

  arm_fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_inst (imem_rdata),
    .push_pc   (push_pc),
    .pop       (pop),
    .clear     (pc_we),
    .head_inst (inst),
    .head_pc   (inst_pc),
    .count     (count)
  );

endmodule

// File: tb/tb_arm_fetch.sv
// tb_arm_fetch: directed + randomized bench for arm_fetch with a
// transaction-level reference model (instruction stream = consecutive
// words from the last redirect target, at most 2 buffered).
module tb_arm_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        pc_we;
  logic [31:0] pc_in;

  logic        w_rst, w_req, w_gnt, w_rvalid, w_valid, w_ready, w_pc_we;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_pc_in;

  always #5 clk = ~clk;

  arm_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .pc_we(pc_we), .pc_in(pc_in)
  );

  arm_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(w_rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .inst_valid(w_valid), .inst_ready(w_ready), .inst(w_inst),
    .inst_pc(w_pc), .pc_we(w_pc_we), .pc_in(w_pc_in)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } pend_t;

  pend_t       pend[$];
  int unsigned cyc, n_assert, n_fail;
  int unsigned mcount;
  logic [31:0] exp_pc, exp_req;
  int unsigned rdy_pct, gnt_pct, lat_min, lat_max;
  bit          granted;
  logic [31:0] granted_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE3A0_1005 ^ a ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] exp_ipc(input logic [31:0] a);
`ifdef ARM_FETCH_PC8_EN
    return a + 32'd8;
`else
    return a;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mcount  = 0;
    exp_pc  = 32'h0;
    exp_req = 32'h0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then
  // advance the model by what the next rising edge will commit.
  task automatic step(input bit we, input logic [31:0] tgt);
    pend_t p;
    int unsigned lat;
    @(negedge clk);
    cyc++;
    granted     = 1'b0;
    inst_ready  = ($urandom_range(99, 0) < rdy_pct);
    pc_we       = we;
    pc_in       = tgt;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    imem_gnt = imem_req ? ($urandom_range(99, 0) < gnt_pct) : $urandom_range(1, 0) == 1;
    #1;
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, mcount != 0});
    chk("imem_req", {31'b0, imem_req}, {31'b0, pend.size() == 0 && mcount < 2 && !we});
    if (we) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      if (imem_rvalid) void'(pend.pop_front());
      mcount  = 0;
      exp_pc  = tgt & 32'hFFFF_FFFC;
      exp_req = tgt & 32'hFFFF_FFFC;
    end else begin
      if (mcount != 0 && inst_ready) begin
        chk("inst", inst, mem_word(exp_pc));
        chk("inst_pc", inst_pc, exp_ipc(exp_pc));
        exp_pc += 32'd4;
        mcount--;
      end
      if (imem_rvalid) begin
        p = pend.pop_front();
        if (!p.stale) mcount++;
      end
      if (imem_req && imem_gnt) begin
        chk("req_addr", imem_addr, exp_req);
        lat = $urandom_range(lat_max, lat_min);
        pend.push_back('{addr: exp_req, due: cyc + lat, stale: 1'b0});
        granted      = 1'b1;
        granted_addr = imem_addr;
        exp_req     += 32'd4;
      end
    end
  endtask

  task automatic reset_checks();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
  endtask

  // Release reset with a stray response in the IDLE cycle; it must be ignored.
  task automatic reset_release();
    @(negedge clk);
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = $urandom;
    imem_gnt    = 1'b1;
    #1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", {31'b0, inst_valid}, 32'd0);
    model_reset();
  endtask

  initial begin
    bit found;
    n_assert = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; pc_we = 1'b0; pc_in = '0; inst_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    w_rst = 1'b1; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
    w_ready = 1'b0; w_pc_we = 1'b0; w_pc_in = '0;
    model_reset();

    // Reset state and start-up.
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    w_rst = 1'b0;
    reset_release();

    // Streaming: 1-cycle memory, always granted, always ready.
    rdy_pct = 100; gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (12) step(1'b0, '0);

    // Decoder stalls: queue fills to 2, requests stop.
    rdy_pct = 0;
    repeat (10) step(1'b0, '0);
    chk("full_valid", {31'b0, inst_valid}, 32'd1);
    chk("full_req", {31'b0, imem_req}, 32'd0);
    rdy_pct = 100;
    repeat (10) step(1'b0, '0);

    // Redirect while a request is outstanding: late response dropped.
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0);
      found = granted;
    end
    chk("wait_out_grant", {31'b0, found}, 32'd1);
    step(1'b1, 32'h0000_0103);
    step(1'b0, '0);
    chk("redir_empty", {31'b0, inst_valid}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0);
      found = granted;
    end
    chk("wait_redir_grant", {31'b0, found}, 32'd1);
    chk("redir_addr", granted_addr, 32'h0000_0100);
    repeat (6) step(1'b0, '0);

    // Redirect in the same cycle as a response: no DROP detour.
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0);
      found = granted;
    end
    chk("wait_coinc_grant", {31'b0, found}, 32'd1);
    step(1'b1, 32'h0000_2002);
    step(1'b0, '0);
    chk("coinc_granted", {31'b0, granted}, 32'd1);
    chk("coinc_addr", granted_addr, 32'h0000_2000);
    repeat (6) step(1'b0, '0);

    // Randomized traffic with occasional redirects.
    rdy_pct = 70; gnt_pct = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(24, 0) == 0) step(1'b1, $urandom);
      else                            step(1'b0, '0);
    end

    // Asynchronous reset while a fetch is in flight with data queued.
    rdy_pct = 0; gnt_pct = 100; lat_min = 3; lat_max = 3;
    step(1'b1, 32'h0000_0400);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, '0);
      found = (mcount == 1) && granted;
    end
    chk("wait_wait_state", {31'b0, found}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; pc_we = 1'b0; inst_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    reset_checks();
    reset_release();
    rdy_pct = 100; gnt_pct = 100; lat_min = 1; lat_max = 2;
    repeat (16) step(1'b0, '0);

    // RESET_PC at the top of the address space wraps to 0.
    @(negedge clk);
    #1;
    chk("wrap_req0", {31'b0, w_req}, 32'd1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_gnt = 1'b1;
    @(negedge clk);
    w_gnt = 1'b0;
    #1;
    chk("wrap_wait_req", {31'b0, w_req}, 32'd0);
    chk("wrap_addr1", w_addr, 32'h0000_0000);
    w_rvalid = 1'b1;
    w_rdata  = 32'hE1A0_0000;
    @(negedge clk);
    w_rvalid = 1'b0;
    #1;
    chk("wrap_req1", {31'b0, w_req}, 32'd1);
    chk("wrap_addr2", w_addr, 32'h0000_0000);
    chk("wrap_valid", {31'b0, w_valid}, 32'd1);
    chk("wrap_inst", w_inst, 32'hE1A0_0000);
    chk("wrap_pc", w_pc, exp_ipc(32'hFFFF_FFFC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
